// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; done pulses WIDTH_N+1 edges after start, start ignored while busy.
// Optional DIV_ZERO_DETECT_EN: adds div_zero and short-circuits a zero divisor straight to DONE.
module seq_divider #(
  parameter int WIDTH_N = 17,
  parameter int WIDTH_D = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic               div_zero
`endif
);

  localparam int CW = $clog2(WIDTH_N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt;
  logic [WIDTH_N-1:0] num;
  logic [WIDTH_D-1:0] den;
  logic [WIDTH_D-1:0] rem_p;

  logic [WIDTH_D:0]   r_shift;
  logic [1:0]         diff_hi;
  logic [WIDTH_D-1:0] diff_lo;
  logic               ge;
  logic [WIDTH_D-1:0] r_next;
  logic [WIDTH_N-1:0] num_next;

  // The partial remainder never needs its top bit stored: the next step
  // only shifts in the low WIDTH_D bits. A negative difference always
  // lands with both high bits set, so that pattern is the borrow.
  always_comb begin
    r_shift              = {rem_p, num[WIDTH_N-1]};
    {diff_hi, diff_lo}   = {1'b0, r_shift} - {2'b00, den};
    ge                   = (diff_hi != 2'b11);
    r_next               = ge ? diff_lo : r_shift[WIDTH_D-1:0];
    num_next             = {num[WIDTH_N-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_DETECT_EN
          state_d = (divisor == '0) ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN:     if (cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt       <= '0;
      num       <= '0;
      den       <= '0;
      rem_p     <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            num   <= dividend;
            den   <= divisor;
            rem_p <= '0;
            cnt   <= CW'(WIDTH_N - 1);
`ifdef DIV_ZERO_DETECT_EN
            div_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[WIDTH_D-1:0];
            end
`endif
          end
        end
        RUN: begin
          num   <= num_next;
          rem_p <= r_next;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            quotient  <= num_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients, remainders and latencies.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] dividend;
  logic [8:0]  divisor;
  logic        busy;
  logic        done;
  logic [16:0] quotient;
  logic [8:0]  remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic        div_zero;
`endif

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH_N(17), .WIDTH_D(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency is counted in edges from the accepting edge (1) to the edge after which done is seen.
  task automatic run_div(input string tag, input logic [16:0] n, input logic [8:0] d,
                         input logic [16:0] exp_q, input logic [8:0] exp_r, input int repulse_at);
    int lat;
    int exp_lat;
    exp_lat = 18;
`ifdef DIV_ZERO_DETECT_EN
    if (d == 9'd0) exp_lat = 1;
`endif
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    check({tag, ".busy"}, busy, 1);
    while (!done && lat < 100) begin
      if (lat == repulse_at) begin
        dividend = 17'd50;
        divisor  = 9'd7;
        start    = 1'b1;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".q"}, quotient, exp_q);
    check({tag, ".r"}, remainder, exp_r);
`ifdef DIV_ZERO_DETECT_EN
    check({tag, ".dz"}, div_zero, (d == 9'd0));
`endif
    tick();
    check({tag, ".done_clr"}, done, 0);
    check({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.q", quotient, 0);
    check("rst.r", remainder, 0);

    run_div("d100000_7", 17'd100000, 9'd7, 17'd14285, 9'd5, 0);
    run_div("d131071_511", 17'd131071, 9'd511, 17'd256, 9'd255, 0);
    run_div("b2b_5_9", 17'd5, 9'd9, 17'd0, 9'd5, 0);

    // Operand toggling in IDLE must not disturb held results
    for (int i = 0; i < 3; i++) begin
      dividend = 17'(1000 + i * 77);
      divisor  = 9'(3 + i);
      tick();
    end
    check("idle.q", quotient, 0);
    check("idle.r", remainder, 5);
    check("idle.done", done, 0);

    run_div("ignored_start", 17'd1000, 9'd3, 17'd333, 9'd1, 5);
    run_div("div1", 17'd54321, 9'd1, 17'd54321, 9'd0, 0);
    run_div("div1_max", 17'd131071, 9'd1, 17'd131071, 9'd0, 0);
    run_div("small", 17'd3, 9'd200, 17'd0, 9'd3, 0);
    run_div("d65535_255", 17'd65535, 9'd255, 17'd257, 9'd0, 0);
    run_div("div0", 17'd1234, 9'd0, 17'd131071, 9'd210, 0);

    // Reset in the middle of a division
    dividend = 17'd1000; divisor = 9'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("abort.busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.q", quotient, 0);
    check("abort.r", remainder, 0);
    seen = 0;
    repeat (25) begin
      tick();
      if (done) seen = 1;
    end
    check("abort.no_done", seen, 0);

    // start coincident with reset is dropped
    dividend = 17'd10; divisor = 9'd3; start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start.busy", busy, 0);
    seen = 0;
    repeat (20) begin
      tick();
      if (done || busy) seen = 1;
    end
    check("rst_start.quiet", seen, 0);

    run_div("after_rst", 17'd77, 9'd10, 17'd7, 9'd7, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
